// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor: a table of 2-bit saturating counters
// indexed by PC[INDEX_BITS+1:2].
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   lookup_valid/pc   fetch-stage query; pred_taken is combinational
//   upd_valid/pc      execute-stage resolved branch
//   upd_taken         actual outcome
//   upd_pred          prediction that travelled with the branch
//   mispredict        registered one-cycle pulse per mispredicting update
//   branch_count      saturating count of resolved branches
//   mispredict_count  saturating count of mispredictions
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            upd_pred,
  output logic            mispredict,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;

  logic [1:0]            ctr_q [Entries];
  logic [1:0]            ctr_d [Entries];
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic                  mispredict_q, mispredict_d;
  logic [31:0]           branch_count_q, branch_count_d;
  logic [31:0]           mispredict_count_q, mispredict_count_d;
  logic                  upd_miss;

  assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
  assign upd_idx    = upd_pc[INDEX_BITS+1:2];
  assign upd_miss   = upd_valid & (upd_taken ^ upd_pred);

  // Reads pre-update state; no bypass from a same-cycle update.
  assign pred_taken = lookup_valid & ctr_q[lookup_idx][1];

  always_comb begin
    ctr_d = ctr_q;
    if (upd_valid) begin
      if (upd_taken) begin
        if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'b01;
      end else begin
        if (ctr_q[upd_idx] != 2'b00) ctr_d[upd_idx] = ctr_q[upd_idx] - 2'b01;
      end
    end
  end

  always_comb begin
    mispredict_d       = upd_miss;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (upd_valid && (branch_count_q != 32'hFFFF_FFFF)) begin
      branch_count_d = branch_count_q + 32'd1;
    end
    if (upd_miss && (mispredict_count_q != 32'hFFFF_FFFF)) begin
      mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) ctr_q[i] <= 2'b01;
      mispredict_q       <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      ctr_q              <= ctr_d;
      mispredict_q       <= mispredict_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign mispredict       = mispredict_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int Entries = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_taken;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        upd_pred = 1'b0;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int total = 0;
  int bad = 0;

  // Behavioural model: counter strength 0..3, taken when >= 2.
  int     strength [Entries];
  bit     exp_misp;
  longint exp_bc;
  longint exp_mc;
  bit     model_ready = 1'b0;

  branch_predictor #(.INDEX_BITS(6), .XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .pred_taken       (pred_taken),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_pred         (upd_pred),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % Entries);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance on each rising edge, using the inputs held across it.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) strength[i] = 1;
      exp_misp    = 1'b0;
      exp_bc      = 0;
      exp_mc      = 0;
      model_ready = 1'b1;
    end else begin
      exp_misp = upd_valid && (upd_taken != upd_pred);
      if (upd_valid) begin
        if (upd_taken) strength[idx_of(upd_pc)] = (strength[idx_of(upd_pc)] == 3) ? 3 :
                                                  strength[idx_of(upd_pc)] + 1;
        else           strength[idx_of(upd_pc)] = (strength[idx_of(upd_pc)] == 0) ? 0 :
                                                  strength[idx_of(upd_pc)] - 1;
        if (exp_bc < 64'hFFFF_FFFF) exp_bc++;
        if (exp_misp && exp_mc < 64'hFFFF_FFFF) exp_mc++;
      end
    end
  end

  // Compare process: every cycle once the model is initialised.
  always @(negedge clk) begin
    if (model_ready) begin
      chk("pred_taken", {31'd0, pred_taken},
          {31'd0, lookup_valid && (strength[idx_of(lookup_pc)] >= 2)});
      chk("mispredict", {31'd0, mispredict}, {31'd0, exp_misp});
      chk("branch_count", branch_count, exp_bc[31:0]);
      chk("mispredict_count", mispredict_count, exp_mc[31:0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic pred);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = taken;
    upd_pred  = pred;
    cyc();
    upd_valid = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    #1;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    look(32'h0000_0000); chk("rst_pred_0", {31'd0, pred_taken}, 32'd0);
    look(32'h0000_00FC); chk("rst_pred_fc", {31'd0, pred_taken}, 32'd0);
    look(32'h0000_1234); chk("rst_pred_1234", {31'd0, pred_taken}, 32'd0);
    chk("rst_bc", branch_count, 32'd0);
    chk("rst_mc", mispredict_count, 32'd0);
    chk("rst_misp", {31'd0, mispredict}, 32'd0);

    // Saturation walk on 0x100
    look(32'h100);
    upd(32'h100, 1'b1, 1'b0);
    chk("walk1_pred", {31'd0, pred_taken}, 32'd1);
    chk("walk1_misp", {31'd0, mispredict}, 32'd1);
    upd(32'h100, 1'b1, 1'b0);
    chk("walk2_pred", {31'd0, pred_taken}, 32'd1);
    chk("walk2_misp", {31'd0, mispredict}, 32'd1);
    upd(32'h100, 1'b1, 1'b0);
    chk("walk3_pred", {31'd0, pred_taken}, 32'd1);
    chk("walk3_misp", {31'd0, mispredict}, 32'd1);
    chk("walk3_strength", strength[0], 32'd3);
    upd(32'h100, 1'b0, 1'b0);
    chk("walk_nt_pred", {31'd0, pred_taken}, 32'd1);
    chk("walk_nt_misp", {31'd0, mispredict}, 32'd0);
    chk("walk_bc", branch_count, 32'd4);

    // Aliasing and isolation
    upd(32'h004, 1'b1, 1'b0);
    upd(32'h004, 1'b1, 1'b0);
    look(32'h104); chk("alias_104", {31'd0, pred_taken}, 32'd1);
    look(32'h008); chk("iso_008", {31'd0, pred_taken}, 32'd0);

    // Same-cycle lookup and update, no bypass
    look(32'h040);
    upd_valid = 1'b1; upd_pc = 32'h040; upd_taken = 1'b1; upd_pred = 1'b0;
    #1;
    chk("same_cyc_pred", {31'd0, pred_taken}, 32'd0);
    cyc();
    upd_valid = 1'b0;
    chk("next_cyc_pred", {31'd0, pred_taken}, 32'd1);

    // Reset mid-operation with a colliding mispredicting update
    upd(32'h200, 1'b1, 1'b1);
    upd(32'h200, 1'b1, 1'b1);
    rst = 1'b1;
    upd(32'h200, 1'b1, 1'b0);
    rst = 1'b0;
    look(32'h200);
    chk("midrst_misp", {31'd0, mispredict}, 32'd0);
    chk("midrst_bc", branch_count, 32'd0);
    chk("midrst_mc", mispredict_count, 32'd0);
    chk("midrst_pred", {31'd0, pred_taken}, 32'd0);

    // 10 updates, 4 mismatches (i = 0,3,6,9)
    for (int i = 0; i < 10; i++) begin
      upd(32'h300 + 32'(i * 4), 1'b1, (i % 3) != 0);
    end
    chk("cnt_bc", branch_count, 32'd10);
    chk("cnt_mc", mispredict_count, 32'd4);

    // Saturation of branch_count via deposit
    @(negedge clk);
    #1;
    dut.branch_count_q = 32'hFFFF_FFFE;
    exp_bc = 64'hFFFF_FFFE;
    @(posedge clk);
    #1;
    upd(32'h010, 1'b1, 1'b1);
    upd(32'h010, 1'b0, 1'b1);
    chk("sat_bc", branch_count, 32'hFFFF_FFFF);
    upd(32'h010, 1'b0, 1'b0);
    chk("sat_bc_hold", branch_count, 32'hFFFF_FFFF);

    // Randomized traffic, with a narrow PC range to force reuse
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      lookup_valid = $urandom_range(0, 1);
      lookup_pc    = $urandom_range(0, 511);
      upd_valid    = $urandom_range(0, 2) != 0;
      upd_pc       = $urandom_range(0, 511);
      upd_taken    = $urandom_range(0, 1);
      upd_pred     = $urandom_range(0, 1);
      cyc();
    end
    rst = 1'b0;
    upd_valid = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch direction predictor for the RV32I core. It holds a table of 2-bit saturating counters indexed by branch PC. The fetch stage queries it for a taken/not-taken prediction. The execute stage then returns the resolved outcome produced by `branch_unit` (`branch_taken`), which trains the table and raises a registered mispredict signal that the pipeline control uses for redirect/flush.

## Interface
Parameters:
- `INDEX_BITS`, 6: table index width. The table has 2^INDEX_BITS entries.
- `XLEN`, 32: PC width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `lookup_valid`  in  1  fetch stage presents a PC for prediction.
- `lookup_pc`  in  XLEN  PC of the fetched instruction.
- `pred_taken`  out  1  prediction for `lookup_pc`; combinational, forced to 0 when `lookup_valid`=0.
- `upd_valid`  in  1  execute stage resolves a conditional branch this cycle (driven by the CU `branch_enable`, qualified by the stage valid).
- `upd_pc`  in  XLEN  PC of the resolved branch.
- `upd_taken`  in  1  actual outcome (`branch_taken` from `branch_unit`).
- `upd_pred`  in  1  prediction carried down the pipeline with that branch.
- `mispredict`  out  1  registered; 1 for one cycle after an update where `upd_taken` != `upd_pred`.
- `branch_count`  out  32  number of resolved branches, saturating.
- `mispredict_count`  out  32  number of mispredictions, saturating.

## Operation
- Index: idx(pc) = pc[INDEX_BITS+1:2]. Bits [1:0] are ignored because instructions are word-aligned.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. The prediction is counter[1].
- Lookup: `pred_taken` = lookup_valid & table[idx(lookup_pc)][1]. The read is purely combinational from registered state.
- Update, on the clock edge when `upd_valid`=1:
  - If `upd_taken`=1, the counter increments and saturates at 11.
  - If `upd_taken`=0, the counter decrements and saturates at 00.
  - Only the entry at idx(upd_pc) changes.
- `mispredict` <= upd_valid & (upd_taken ^ upd_pred). It is 0 in any cycle whose previous edge had `upd_valid`=0.
- Statistics:
  - `branch_count` increments by 1 on each update.
  - `mispredict_count` increments by 1 on each mispredicting update.
  - Both hold at 32'hFFFF_FFFF once reached and do not wrap.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update counter value. There is no bypass; the new value is visible from the next cycle.
- Aliasing: PCs that share an index share a counter. This is intended and not detected.
- `upd_pred` is trusted as given. The block does not recompute it from the table.

## Timing
- Reset (`rst`=1 at a rising edge):
  - All table entries <= 01 (weak-NT).
  - `mispredict` <= 0.
  - `branch_count` <= 0 and `mispredict_count` <= 0.
  - `pred_taken` therefore reads 0 for every PC after reset.
- Reset has priority over a simultaneous update. An update presented in the reset cycle is discarded and not counted.
- Lookup latency is 0 cycles (same-cycle combinational output).
- Update latency: the table changes at the edge where `upd_valid`=1. `mispredict` and the counters are visible from the following cycle.
- `mispredict` is a single-cycle pulse per mispredicting update. Back-to-back mispredicting updates produce `mispredict` held high for consecutive cycles.
- No handshake and no backpressure: one update and one lookup are accepted every cycle.

## Test plan
- Reset state:
  - Stimulus: assert `rst` for 1 cycle, then look up PC 0x0000_0000, 0x0000_00FC and 0x0000_1234.
  - Required: `pred_taken`=0 for all three; `branch_count`=0, `mispredict_count`=0, `mispredict`=0.
- Saturation walk on PC 0x100 (upd_pred=0 throughout):
  - Stimulus: apply 3 taken updates.
  - Required: the prediction for 0x100 goes 0→1 after the first update and stays 1. `mispredict` pulses on each update. The counter reaches 11.
  - Stimulus: then apply 1 not-taken update.
  - Required: the prediction is still 1 (counter at 10).
- Aliasing and index isolation:
  - Stimulus: 2 taken updates at PC 0x004.
  - Required: the lookup at 0x104 (same index with INDEX_BITS=6) predicts 1; the lookup at 0x008 predicts 0.
- Same-cycle lookup and update to PC 0x040 (counter at 01):
  - Stimulus: `upd_taken`=1 while lookup_pc=0x040.
  - Required: `pred_taken`=0 in that cycle and 1 in the next cycle.
- Reset mid-operation:
  - Stimulus: train PC 0x200 to 11, then assert `rst` together with `upd_valid`=1 and `upd_taken`^`upd_pred`=1.
  - Required: next cycle `mispredict`=0, both counters are 0, and the 0x200 prediction is 0.
- Counter behaviour:
  - Stimulus: 10 updates with 4 mismatches.
  - Required: `branch_count`=10 and `mispredict_count`=4.
  - Stimulus: force `branch_count` near its maximum (via a testbench hierarchical deposit of 32'hFFFF_FFFE), then apply 2 updates.
  - Required: `branch_count` holds at 32'hFFFF_FFFF.
